// File: rtl/pattern_scan_ctrl_if.sv
// Bundles the configuration, control, serial-data and status signals of the
// pattern scanner so the controller and its driver share one port.
interface pattern_scan_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pat;
    logic [CNT_W-1:0] cfg_target;
    logic             start;
    logic             abort;
    logic             w;
    logic             ack;

    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;

    modport master (
        output cfg_we, cfg_pat, cfg_target, start, abort, w, ack,
        input  z, match_cnt, busy, done
    );

    modport slave (
        input  cfg_we, cfg_pat, cfg_target, start, abort, w, ack,
        output z, match_cnt, busy, done
    );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: counts (overlapping) occurrences of a latched
// pattern in a bit stream until a latched target count is reached or aborted.
module pattern_scan_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pattern_scan_ctrl_if.slave   bus
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [PAT_W-1:0]  shift_q, shift_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              z_q, z_d;

    logic [PAT_W-1:0]  shift_nx;
    logic [FILL_W-1:0] fill_nx;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  start_target;
    logic              match_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            target_q <= '0;
            shift_q  <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            target_q <= target_d;
            shift_q  <= shift_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        target_d     = target_q;
        shift_d      = shift_q;
        fill_d       = fill_q;
        cnt_d        = cnt_q;
        z_d          = 1'b0;

        shift_nx     = {shift_q[PAT_W-2:0], bus.w};
        fill_nx      = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        cnt_inc      = cnt_q + CNT_W'(1);
        match_hit    = (fill_nx == FILL_FULL) && (shift_nx == pat_q);
        // A config write on the start edge applies to the scan it starts.
        start_target = bus.cfg_we ? bus.cfg_target : target_q;

        case (state_q)
            IDLE: begin
                if (bus.cfg_we) begin
                    pat_d    = bus.cfg_pat;
                    target_d = bus.cfg_target;
                end
                if (bus.start) begin
                    shift_d = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                    state_d = (start_target == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                // Abort wins over a coincident match: no pulse, no increment.
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    shift_d = shift_nx;
                    fill_d  = fill_nx;
                    if (match_hit) begin
                        z_d   = 1'b1;
                        cnt_d = cnt_inc;
                        if (cnt_inc == target_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (bus.ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.z         = z_q;
    assign bus.match_cnt = cnt_q;
    assign bus.busy      = (state_q == SCAN);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Vector-table bench for pattern_scan_ctrl with a scoreboard queue of expected outputs.
module tb_pattern_scan_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pattern_scan_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    pattern_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       cfg_we;
        logic [3:0] cfg_pat;
        logic [7:0] cfg_target;
        logic       start;
        logic       abort;
        logic       w;
        logic       ack;
        logic       exp_z;
        logic [7:0] exp_cnt;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    typedef struct packed {
        logic       z;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
    } out_t;

    vec_t vecs[$];
    out_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic we, input logic [3:0] pat, input logic [7:0] tgt,
                                input logic st, input logic ab, input logic wb, input logic ak,
                                input logic ez, input logic [7:0] ec, input logic eb, input logic ed);
        vec_t v;
        v.cfg_we = we;  v.cfg_pat = pat; v.cfg_target = tgt;
        v.start = st;   v.abort = ab;    v.w = wb;    v.ack = ak;
        v.exp_z = ez;   v.exp_cnt = ec;  v.exp_busy = eb; v.exp_done = ed;
        return v;
    endfunction

    // Plain scan-cycle vector: only w driven, still busy afterwards.
    function automatic vec_t sc(input logic wb, input logic ez, input logic [7:0] ec);
        return mk(1'b0, 4'h0, 8'd0, 1'b0, 1'b0, wb, 1'b0, ez, ec, 1'b1, 1'b0);
    endfunction

    task automatic check_out(input string name);
        out_t a;
        out_t e;
        a.z = bus.z; a.cnt = bus.match_cnt; a.busy = bus.busy; a.done = bus.done;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got z=%0b cnt=%0d busy=%0b done=%0b",
                     name, a.z, a.cnt, a.busy, a.done);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got z=%0b cnt=%0d busy=%0b done=%0b, expected z=%0b cnt=%0d busy=%0b done=%0b",
                         name, a.z, a.cnt, a.busy, a.done, e.z, e.cnt, e.busy, e.done);
            end else begin
                $display("ok   %s: z=%0b cnt=%0d busy=%0b done=%0b", name, a.z, a.cnt, a.busy, a.done);
            end
        end
    endtask

    task automatic expect_out(input logic ez, input logic [7:0] ec, input logic eb, input logic ed);
        out_t e;
        e.z = ez; e.cnt = ec; e.busy = eb; e.done = ed;
        sb.push_back(e);
    endtask

    task automatic apply(input vec_t v, input string name);
        bus.cfg_we     = v.cfg_we;
        bus.cfg_pat    = v.cfg_pat;
        bus.cfg_target = v.cfg_target;
        bus.start      = v.start;
        bus.abort      = v.abort;
        bus.w          = v.w;
        bus.ack        = v.ack;
        expect_out(v.exp_z, v.exp_cnt, v.exp_busy, v.exp_done);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    initial begin
        vec_t hand[$];

        // Two overlapping-capable matches reach target 2; start in DONE ignored; ack; abort in IDLE ignored.
        vecs.push_back(mk(1, 4'b1011, 8'd2, 1, 0, 0, 0, 0, 8'd0, 1, 0));
        vecs.push_back(sc(1, 0, 8'd0));
        vecs.push_back(sc(0, 0, 8'd0));
        vecs.push_back(sc(1, 0, 8'd0));
        vecs.push_back(sc(1, 1, 8'd1));
        vecs.push_back(sc(0, 0, 8'd1));
        vecs.push_back(sc(1, 0, 8'd1));
        vecs.push_back(mk(0, 4'h0, 8'd0, 0, 0, 1, 0, 1, 8'd2, 0, 1));
        vecs.push_back(mk(0, 4'h0, 8'd0, 1, 0, 0, 0, 0, 8'd2, 0, 1));
        vecs.push_back(mk(0, 4'h0, 8'd0, 0, 0, 0, 1, 0, 8'd2, 0, 0));
        vecs.push_back(mk(0, 4'h0, 8'd0, 0, 1, 0, 0, 0, 8'd2, 0, 0));
        // Fill gating, single match, then abort keeps count.
        vecs.push_back(mk(1, 4'b1011, 8'd3, 1, 0, 0, 0, 0, 8'd0, 1, 0));
        vecs.push_back(sc(0, 0, 8'd0));
        vecs.push_back(sc(1, 0, 8'd0));
        vecs.push_back(sc(1, 0, 8'd0));
        vecs.push_back(sc(1, 0, 8'd0));
        vecs.push_back(sc(0, 0, 8'd0));
        vecs.push_back(sc(1, 0, 8'd0));
        vecs.push_back(sc(1, 1, 8'd1));
        vecs.push_back(mk(0, 4'h0, 8'd0, 0, 1, 1, 0, 0, 8'd1, 0, 0));
        // Final match coincident with abort.
        vecs.push_back(mk(1, 4'b1011, 8'd2, 1, 0, 0, 0, 0, 8'd0, 1, 0));
        vecs.push_back(sc(1, 0, 8'd0));
        vecs.push_back(sc(0, 0, 8'd0));
        vecs.push_back(sc(1, 0, 8'd0));
        vecs.push_back(sc(1, 1, 8'd1));
        vecs.push_back(sc(0, 0, 8'd1));
        vecs.push_back(sc(1, 0, 8'd1));
        vecs.push_back(mk(0, 4'h0, 8'd0, 0, 1, 1, 0, 0, 8'd1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 8'd0, 0, 0, 0, 0, 0, 8'd1, 0, 0));
        // Config writes during SCAN and DONE are ignored.
        vecs.push_back(mk(1, 4'b1011, 8'd1, 1, 0, 0, 0, 0, 8'd0, 1, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 4'b1111, 8'd0, 0, 0, 1, 0, 0, 8'd0, 1, 0));
        vecs.push_back(sc(1, 0, 8'd0));
        vecs.push_back(sc(0, 0, 8'd0));
        vecs.push_back(sc(1, 0, 8'd0));
        vecs.push_back(mk(0, 4'h0, 8'd0, 0, 0, 1, 0, 1, 8'd1, 0, 1));
        vecs.push_back(mk(1, 4'b0000, 8'd7, 0, 0, 0, 0, 0, 8'd1, 0, 1));
        vecs.push_back(mk(0, 4'h0, 8'd0, 0, 0, 0, 1, 0, 8'd1, 0, 0));
        vecs.push_back(mk(0, 4'h0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0));
        vecs.push_back(sc(1, 0, 8'd0));
        vecs.push_back(sc(0, 0, 8'd0));
        vecs.push_back(sc(1, 0, 8'd0));
        vecs.push_back(mk(0, 4'h0, 8'd0, 0, 0, 1, 0, 1, 8'd1, 0, 1));
        vecs.push_back(mk(0, 4'h0, 8'd0, 0, 0, 0, 1, 0, 8'd1, 0, 0));
        // Target 0 completes at once; ack with start returns to IDLE without scanning.
        vecs.push_back(mk(1, 4'b1011, 8'd0, 1, 0, 0, 0, 0, 8'd0, 0, 1));
        vecs.push_back(mk(0, 4'h0, 8'd0, 1, 0, 0, 1, 0, 8'd0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 0, 0));

        bus.cfg_we = 0; bus.cfg_pat = '0; bus.cfg_target = '0;
        bus.start = 0; bus.abort = 0; bus.w = 0; bus.ack = 0;

        // Outputs held at zero while in reset, across a clock edge.
        #3;
        expect_out(0, 8'd0, 0, 0);
        check_out("reset_hold");
        @(posedge clk);
        #1;
        expect_out(0, 8'd0, 0, 0);
        check_out("reset_edge");
        #2 rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset pulse mid-scan after two matches.
        apply(mk(1, 4'b1011, 8'd5, 1, 0, 0, 0, 0, 8'd0, 1, 0), "rs_start");
        apply(sc(1, 0, 8'd0), "rs_b1");
        apply(sc(0, 0, 8'd0), "rs_b2");
        apply(sc(1, 0, 8'd0), "rs_b3");
        apply(sc(1, 1, 8'd1), "rs_b4");
        apply(sc(0, 0, 8'd1), "rs_b5");
        apply(sc(1, 0, 8'd1), "rs_b6");
        apply(sc(1, 1, 8'd2), "rs_b7");
        #1 rst = 1'b0;
        #1;
        expect_out(0, 8'd0, 0, 0);
        check_out("rs_async_low");
        #4 rst = 1'b1;

        // Latched config was cleared: target 0 ends immediately; then pattern 0000 overlaps.
        hand.push_back(mk(0, 4'h0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 0, 0));
        hand.push_back(mk(0, 4'h0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 0, 1));
        hand.push_back(mk(0, 4'h0, 8'd0, 0, 0, 0, 1, 0, 8'd0, 0, 0));
        hand.push_back(mk(1, 4'b0000, 8'd2, 1, 0, 0, 0, 0, 8'd0, 1, 0));
        hand.push_back(sc(0, 0, 8'd0));
        hand.push_back(sc(0, 0, 8'd0));
        hand.push_back(sc(0, 0, 8'd0));
        hand.push_back(sc(0, 1, 8'd1));
        hand.push_back(mk(0, 4'h0, 8'd0, 0, 0, 0, 0, 1, 8'd2, 0, 1));
        hand.push_back(mk(0, 4'h0, 8'd0, 0, 0, 0, 1, 0, 8'd2, 0, 0));
        for (int i = 0; i < hand.size(); i++)
            apply(hand[i], $sformatf("post_rst%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
